// File: rtl/disp_share_arbiter_pkg.sv
// Shared constants and types for the display-sharing arbiter: blank code,
// active-low hex-to-segment table (bit6=a .. bit0=g) and FSM state encoding.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } disp_state_e;

endpackage

// File: rtl/disp_share_arbiter_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment code.
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the four-digit display: grants one requester, latches
// its 16-bit value, shows it for a dwell time. Optional DISP_LEADING_ZERO_BLANK_EN.
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 32,
  localparam int GW          = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] val,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [GW-1:0]       grant_id,
  output logic                disp_en,
  output logic [6:0]          b1,
  output logic [6:0]          b2,
  output logic [6:0]          b3,
  output logic [6:0]          b4,
  output disp_state_e         state_o
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  // Handshake: req is a level held by the requester for as long as it wants
  // the display; ack pulses once when its value is latched, done pulses once
  // when its slot ends. Dropping req during its slot ends the slot early.

  disp_state_e       state_q;
  logic [GW-1:0]     rr_q;
  logic [GW-1:0]     grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       val_q;
  logic [N_REQ-1:0]  ack_q;
  logic [N_REQ-1:0]  done_q;
  logic              busy_q;
  logic              en_q;

  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  int                idx;

  // Descending scan so the lowest circular offset from rr_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            val_q   <= val[16*int'(pick_idx) +: 16];
            ack_q   <= N_REQ'(1) << pick_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            en_q    <= 1'b1;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (!req[grant_q] || (cnt_q == DWELL_LAST)) begin
            done_q  <= N_REQ'(1) << grant_q;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            rr_q    <= (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [6:0] seg_raw [4];

  hex_to_seg7 u_seg3 (.nib_i(val_q[15:12]), .seg_o(seg_raw[3]));
  hex_to_seg7 u_seg2 (.nib_i(val_q[11:8]),  .seg_o(seg_raw[2]));
  hex_to_seg7 u_seg1 (.nib_i(val_q[7:4]),   .seg_o(seg_raw[1]));
  hex_to_seg7 u_seg0 (.nib_i(val_q[3:0]),   .seg_o(seg_raw[0]));

  // lz[k] marks digit k as a leading zero; the last digit is never masked.
  logic [3:0] lz;
`ifdef DISP_LEADING_ZERO_BLANK_EN
  assign lz[3] = (val_q[15:12] == 4'h0);
  assign lz[2] = lz[3] && (val_q[11:8] == 4'h0);
  assign lz[1] = lz[2] && (val_q[7:4] == 4'h0);
  assign lz[0] = 1'b0;
`else
  assign lz = 4'b0000;
`endif

  assign b1 = (!en_q || lz[3]) ? SEG_BLANK : seg_raw[3];
  assign b2 = (!en_q || lz[2]) ? SEG_BLANK : seg_raw[2];
  assign b3 = (!en_q || lz[1]) ? SEG_BLANK : seg_raw[1];
  assign b4 = (!en_q || lz[0]) ? SEG_BLANK : seg_raw[0];

  assign ack      = ack_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign disp_en  = en_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter with DWELL_CYCLES=8, N_REQ=4.
module tb_disp_share_arbiter;
  import disp_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [16*N-1:0]   val;
  logic [N-1:0]      ack;
  logic [N-1:0]      done;
  logic              busy;
  logic [1:0]        grant_id;
  logic              disp_en;
  logic [6:0]        b1, b2, b3, b4;
  disp_state_e       state_o;

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q[$];

  disp_share_arbiter #(.N_REQ(N), .DWELL_CYCLES(DW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .val(val), .ack(ack), .done(done),
    .busy(busy), .grant_id(grant_id), .disp_en(disp_en),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .state_o(state_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_segs(input string tag, input logic [6:0] e1, input logic [6:0] e2,
                            input logic [6:0] e3, input logic [6:0] e4);
    check({tag, ".b1"}, 32'(b1), 32'(e1));
    check({tag, ".b2"}, 32'(b2), 32'(e2));
    check({tag, ".b3"}, 32'(b3), 32'(e3));
    check({tag, ".b4"}, 32'(b4), 32'(e4));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_segs(tag, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK);
    check({tag, ".disp_en"}, 32'(disp_en), 32'd0);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".ack"},     32'(ack),     32'd0);
    check({tag, ".done"},    32'(done),    32'd0);
  endtask

  // Waits (bounded) for the next ack; n = negedges elapsed.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 40);
  endtask

  int n;
  int en_cnt;
  logic [1:0] g;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    val   = '0;
    repeat (2) tick();

    // Reset state
    check_idle_outputs("reset");
    check("reset.grant_id", 32'(grant_id), 32'd0);
    check("reset.state",    32'(state_o),  32'(IDLE));
    rst_n = 1'b1;
    tick();
    check_idle_outputs("idle_noreq");

    // Single grant of requester 2 with full dwell
    req = 4'b0100;
    val[47:32] = 16'h12A0;
    tick();
    check("g2.ack",      32'(ack),      32'b0100);
    check("g2.grant_id", 32'(grant_id), 32'd2);
    check("g2.busy",     32'(busy),     32'd1);
    check_segs("g2", 7'h4F, 7'h12, 7'h08, 7'h01);
    en_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!disp_en) break;
      en_cnt++;
    end
    check("g2.en_cycles", 32'(en_cnt), 32'd8);
    check("g2.done",      32'(done),   32'b0100);
    check("g2.state",     32'(state_o), 32'(DONE));
    check_segs("g2.done_blank", SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK);
    req = '0;
    tick();
    check("g2.done_clear", 32'(done), 32'd0);
    tick();
    check_idle_outputs("g2.after");

    // Asynchronous reset in the middle of a slot
    req = 4'b0010;
    val[31:16] = 16'h5678;
    tick();
    check("rst_mid.ack", 32'(ack), 32'b0010);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid.grant_id", 32'(grant_id), 32'd0);
    check("rst_mid.state",    32'(state_o),  32'(IDLE));
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid.no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // All four requesting: round-robin order and spacing
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    val = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      g = exp_q.pop_front();
      check("rr.ack_seen", 32'(ack != '0), 32'd1);
      check("rr.grant_id", 32'(grant_id), 32'(g));
      check("rr.ack",      32'(ack),      32'(4'b0001 << g));
      if (k > 0) check("rr.spacing", 32'(n), 32'd10);
    end
    req = '0;
    repeat (3) tick();
    check("rr.drained", 32'(state_o), 32'(IDLE));

    // Early release of requester 1; value changes ignored during slot
    req = 4'b0010;
    val[31:16] = 16'hBEEF;
    tick();
    check("er.ack", 32'(ack), 32'b0010);
    check_segs("er.c1", 7'h60, 7'h30, 7'h30, 7'h38);
    val[31:16] = 16'h0000;
    tick();
    check_segs("er.c2", 7'h60, 7'h30, 7'h30, 7'h38);
    tick();
    check("er.c3_busy", 32'(busy), 32'd1);
    req = '0;
    tick();
    check("er.done",    32'(done),    32'b0010);
    check("er.disp_en", 32'(disp_en), 32'd0);
    check_segs("er.blank", SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK);
    tick();
    check("er.done_clear", 32'(done), 32'd0);

    // Leading-zero handling, single-requester regrant, pointer wrap
    req = 4'b1000;
    val[63:48] = 16'h0003;
    tick();
    check("lz.ack", 32'(ack), 32'b1000);
`ifdef DISP_LEADING_ZERO_BLANK_EN
    check_segs("lz", SEG_BLANK, SEG_BLANK, SEG_BLANK, 7'h06);
`else
    check_segs("lz", 7'h01, 7'h01, 7'h01, 7'h06);
`endif
    wait_ack(n);
    check("regrant.spacing",  32'(n),        32'd10);
    check("regrant.grant_id", 32'(grant_id), 32'd3);
    check("regrant.ack",      32'(ack),      32'b1000);
    req = 4'b0101;
    wait_ack(n);
    check("wrap.spacing",  32'(n),        32'd3);
    check("wrap.grant_id", 32'(grant_id), 32'd0);
    check("wrap.ack",      32'(ack),      32'b0001);
    req = '0;
    repeat (3) tick();
    check_idle_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disp_share_arbiter.md
# disp_share_arbiter

Round-robin arbiter that shares the four-digit seven-segment display between up to N_REQ requesters (register view, PC, ALU result, fault codes). It grants one requester at a time and latches that requester's 16-bit value. The value is converted to per-digit segment codes and holds the display for a fixed dwell time. Its b1..b4 and disp_en outputs drive the digit-multiplexing display module directly.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- DWELL_CYCLES, default 50_000_000: SHOW duration in clk cycles, ≥2.
- CNT_W, default 32: dwell counter width; must hold DWELL_CYCLES-1.
- clk  in  1: system clock; all state updates on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req  in  N_REQ: level request per requester.
- val  in  16*N_REQ: requester i value in val[16*i+15:16*i].
- ack  out  N_REQ: one-cycle pulse to the requester whose value was latched.
- done  out  N_REQ: one-cycle pulse to the granted requester when its slot ends.
- busy  out  1: high in SHOW.
- grant_id  out  $clog2(N_REQ): index of the current or last grant.
- disp_en  out  1: display enable, high only in SHOW.
- b1, b2, b3, b4  out  7 each: segment codes, active-low, bit6=a … bit0=g.
  - b1 is the most significant nibble; b4 is the least significant nibble.

## Operation
- States: IDLE, SHOW, DONE.
- Reset values: state IDLE; ack=0, done=0, busy=0, disp_en=0, grant_id=0; b1..b4=7'h7F (blank); RR pointer=0; counter=0.
- IDLE, no req: outputs stay blank and disp_en=0.
- IDLE, any req:
  - Grant the first asserted index found searching upward, circularly, from the RR pointer.
  - Latch its val slice and decode to b1..b4.
  - Set grant_id, pulse ack[grant], clear the counter, go to SHOW.
- SHOW, normal end: counter increments each cycle. When counter==DWELL_CYCLES-1, go to DONE.
- SHOW, early release: if req[grant_id] is low at an edge, go to DONE immediately.
- SHOW, value changes: changes on val are ignored; the value is latched once per grant.
- SHOW, other requesters: their req is ignored. There is no preemption.
- DONE:
  - Pulse done[grant_id].
  - Set RR pointer = grant_id+1, wrapping at N_REQ.
  - Blank b1..b4 and drop disp_en.
  - Go to IDLE.
- A requester that holds req through DONE competes normally in IDLE. If it is the only requester, it is re-granted.
- Hex decode, 0..F, active-low:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38

## Timing
- req first high at edge k, seen in IDLE: after edge k, ack is high for one cycle and b1..b4, grant_id, busy, disp_en are all valid.
- SHOW with no release: disp_en stays high for exactly DWELL_CYCLES cycles.
- After SHOW: one DONE cycle with done high and blank outputs, then one IDLE cycle.
- Minimum grant-to-grant spacing: DWELL_CYCLES+2 cycles.
- Early release: req low sampled at edge m → DONE after edge m.
- All outputs are registered; there is no combinational path from req or val to any output.
- rst_n low at any time, including mid-SHOW: all outputs go to reset values asynchronously. No done pulse is issued for the aborted grant.

## Configuration
- DISP_LEADING_ZERO_BLANK_EN defined:
  - Leading zero nibbles, scanning from b1 toward b3, decode to 7'h7F.
  - b4 always shows its digit. Example: 16'h0000 → b4 shows "0".
- Not defined: all four digits always show their hex digit.

## Structure
- Package disp_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry hex-to-segment constant table.
  - The state enum {IDLE, SHOW, DONE}.
- One sub-module, hex_to_seg7: combinational nibble → 7-bit code, instantiated four times on the latched value.
- Leading-zero masking lives in the parent.

## Test plan
All scenarios use DWELL_CYCLES=8.
- Reset → b1..b4=7F, disp_en=0, ack=0, done=0. Assert rst_n mid-SHOW → same values immediately; no done pulse.
- req[2]=1, val2=16'h12A0 → next cycle ack[2]=1, grant_id=2, b1..b4 = 4F,12,08,01. disp_en high for exactly 8 cycles, then done[2] for 1 cycle.
- req[0..3] all held high → grant order 0,1,2,3,0. Grants are spaced exactly 10 cycles apart.
- req[1] dropped on the 3rd SHOW cycle → DONE next cycle and done[1] pulses. val changes during SHOW do not alter b1..b4.
- DISP_LEADING_ZERO_BLANK_EN defined, val=16'h0003 → b1..b4 = 7F,7F,7F,06. Undefined → 01,01,01,06.
- Single requester held high → re-granted after DONE+IDLE. RR pointer wraps from N_REQ-1 to 0.
